// File: rtl/addsub_seq.sv
// Chunked two's-complement add/sub: CHUNK bits per clock, result and flags registered with done, NCHUNK+1 cycles after start.
// start is ignored while busy; define ADDSUB_SEQ_SATURATE_EN to clamp z on signed overflow.
module addsub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic             i_ci,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_z,
  output logic             o_co,
  output logic             o_oflow,
  output logic             o_zero,
  output logic             o_neg,
  output logic             o_busy,
  output logic             o_done
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_z;
  logic             r_co, r_oflow, r_zero, r_neg;

  logic             w_accept, w_last, w_oflow;
  logic [CHUNK:0]   w_chunk;
  logic [WIDTH-1:0] w_sum_nxt, w_z_final;

  assign w_accept = i_start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_idx == IDXW'(NCHUNK - 1));

  // Operands shift right each cycle, so the low chunk is always the one being added.
  assign w_chunk   = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_sum_nxt = WIDTH'({w_chunk[CHUNK-1:0], r_sum} >> CHUNK);
  assign w_oflow   = (r_a[CHUNK-1] == r_b[CHUNK-1]) && (w_chunk[CHUNK-1] != r_a[CHUNK-1]);

`ifdef ADDSUB_SEQ_SATURATE_EN
  assign w_z_final = w_oflow ? {r_a[CHUNK-1], {(WIDTH-1){~r_a[CHUNK-1]}}} : w_sum_nxt;
`else
  assign w_z_final = w_sum_nxt;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = i_start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_RUN:   o_busy = 1'b1;
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_z     <= '0;
      r_co    <= 1'b0;
      r_oflow <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b ^ {WIDTH{i_sub}};
      r_carry <= i_sub ? ~i_ci : i_ci;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_carry <= w_chunk[CHUNK];
      r_sum   <= w_sum_nxt;
      r_idx   <= r_idx + IDXW'(1);
      if (w_last) begin
        r_z     <= w_z_final;
        r_co    <= w_chunk[CHUNK];
        r_oflow <= w_oflow;
        r_zero  <= (w_z_final == '0);
        r_neg   <= w_z_final[WIDTH-1];
      end
    end
  end

  assign o_z     = r_z;
  assign o_co    = r_co;
  assign o_oflow = r_oflow;
  assign o_zero  = r_zero;
  assign o_neg   = r_neg;
endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq (WIDTH=8, CHUNK=4): vector table, handshake sequences, random ops vs arithmetic model.
module tb_addsub_seq;
  logic       i_clk, i_rst, i_start, i_sub, i_ci;
  logic [7:0] i_a, i_b, o_z;
  logic       o_co, o_oflow, o_zero, o_neg, o_busy, o_done;

  int checks = 0;
  int errors = 0;

  addsub_seq #(.WIDTH(8), .CHUNK(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_sub(i_sub), .i_ci(i_ci),
    .i_a(i_a), .i_b(i_b), .o_z(o_z), .o_co(o_co), .o_oflow(o_oflow),
    .o_zero(o_zero), .o_neg(o_neg), .o_busy(o_busy), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       ci;
    logic [7:0] z;
    logic       co;
    logic       ofl;
    logic       zr;
    logic       ng;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the full values.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                                output logic [7:0] z, output logic co, output logic ofl,
                                output logic zr, output logic ng);
    int sa, sb, r, u;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      r  = sa + sb + int'(c);
      u  = int'(a) + int'(b) + int'(c);
      co = (u > 255);
    end else begin
      r  = sa - sb - int'(c);
      u  = int'(a) - int'(b) - int'(c);
      co = (u >= 0);
    end
    z   = r[7:0];
    ofl = (r > 127) || (r < -128);
`ifdef ADDSUB_SEQ_SATURATE_EN
    if (ofl) z = a[7] ? 8'h80 : 8'h7F;
`endif
    zr = (z == 8'h00);
    ng = z[7];
  endfunction

  // Called #1 after a clock edge; returns #1 after the edge where done is seen.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                       output int lat, output bit stable);
    logic [7:0] zb;
    zb      = o_z;
    i_a     = a;
    i_b     = b;
    i_sub   = s;
    i_ci    = c;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_a     = 8'($urandom);
    i_b     = 8'($urandom);
    i_sub   = 1'($urandom);
    i_ci    = 1'($urandom);
    lat     = 0;
    stable  = 1'b1;
    while (!o_done && lat < 20) begin
      if (o_z !== zb) stable = 1'b0;
      @(posedge i_clk); #1;
      lat++;
    end
  endtask

  vec_t       tbl[6];
  int         lat;
  bit         stable, seen_done;
  logic [7:0] ez;
  logic       eco, eofl, ezr, eng;

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_sub = 1'b0; i_ci = 1'b0; i_a = 8'h00; i_b = 8'h00;

    tbl[0] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef ADDSUB_SEQ_SATURATE_EN
    tbl[4] = '{8'h70, 8'h10, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    tbl[4] = '{8'h70, 8'h10, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
`endif

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_z", o_z, 0);
    chk("rst_co", o_co, 0);
    chk("rst_oflow", o_oflow, 0);
    chk("rst_zero", o_zero, 0);
    chk("rst_neg", o_neg, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].ci, lat, stable);
      chk($sformatf("vec%0d_latency", i), lat, 2);
      chk($sformatf("vec%0d_stable", i), stable, 1);
      chk($sformatf("vec%0d_z", i), o_z, tbl[i].z);
      chk($sformatf("vec%0d_co", i), o_co, tbl[i].co);
      chk($sformatf("vec%0d_oflow", i), o_oflow, tbl[i].ofl);
      chk($sformatf("vec%0d_zero", i), o_zero, tbl[i].zr);
      chk($sformatf("vec%0d_neg", i), o_neg, tbl[i].ng);
      @(posedge i_clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), o_done, 0);
    end

    // start while busy is ignored
    i_a = 8'h05; i_b = 8'h03; i_sub = 1'b0; i_ci = 1'b0; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_a = 8'h40; i_b = 8'h40; i_sub = 1'b1; i_ci = 1'b1; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("ign_busy", o_busy, 1);
    @(posedge i_clk); #1;
    chk("ign_done", o_done, 1);
    chk("ign_z", o_z, 8'h08);
    @(posedge i_clk); #1;
    chk("ign_idle_done", o_done, 0);
    chk("ign_idle_busy", o_busy, 0);

    // start during DONE is accepted
    do_op(8'h11, 8'h22, 1'b0, 1'b0, lat, stable);
    chk("b2b_first_z", o_z, 8'h33);
    i_a = 8'h01; i_b = 8'h01; i_sub = 1'b1; i_ci = 1'b0; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("b2b_busy", o_busy, 1);
    chk("b2b_no_done", o_done, 0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("b2b_done", o_done, 1);
    chk("b2b_z", o_z, 8'h00);
    chk("b2b_zero", o_zero, 1);
    chk("b2b_co", o_co, 1);

    // reset mid-operation
    do_op(8'h12, 8'h34, 1'b0, 1'b0, lat, stable);
    chk("pre_rst_z", o_z, 8'h46);
    i_a = 8'h55; i_b = 8'h11; i_sub = 1'b0; i_ci = 1'b0; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_z", o_z, 0);
    chk("abort_flags", {o_co, o_oflow, o_zero, o_neg}, 0);
    seen_done = 1'b0;
    repeat (4) begin
      @(posedge i_clk); #1;
      if (o_done) seen_done = 1'b1;
    end
    chk("abort_no_done", seen_done, 0);
    do_op(8'h21, 8'h01, 1'b1, 1'b0, lat, stable);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_z", o_z, 8'h20);

    // random operations against the model
    for (int n = 0; n < 150; n++) begin
      logic [7:0] ra, rb;
      logic       rs, rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      model(ra, rb, rs, rc, ez, eco, eofl, ezr, eng);
      do_op(ra, rb, rs, rc, lat, stable);
      chk($sformatf("rnd%0d_latency", n), lat, 2);
      chk($sformatf("rnd%0d_stable", n), stable, 1);
      chk($sformatf("rnd%0d_z a=%0h b=%0h s=%0d c=%0d", n, ra, rb, rs, rc), o_z, ez);
      chk($sformatf("rnd%0d_co", n), o_co, eco);
      chk($sformatf("rnd%0d_oflow", n), o_oflow, eofl);
      chk($sformatf("rnd%0d_zero", n), o_zero, ezr);
      chk($sformatf("rnd%0d_neg", n), o_neg, eng);
      repeat ($urandom_range(0, 2)) begin
        @(posedge i_clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor for the datapath library.
- Processes operands CHUNK bits per clock, LSB chunk first, with a registered inter-chunk carry.
- Uses a start/busy/done handshake and reports carry, overflow, zero and negative flags with the result.
- Trades latency for a short carry chain. Intended for wide operands where a full-width ripple does not close timing.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be ≥ 2 and an integer multiple of CHUNK.
- CHUNK, 4: bits processed per clock. NCHUNK = WIDTH/CHUNK is derived and not user-settable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = add, 1 = subtract; latched on an accepted start.
- ci  input  1  carry-in for add, borrow-in for sub; latched on an accepted start.
- a  input  WIDTH  signed operand A; latched on an accepted start.
- b  input  WIDTH  signed operand B; latched on an accepted start.
- z  output  WIDTH  signed result, registered.
- co  output  1  raw carry out of the MSB. For sub, 1 = no borrow.
- oflow  output  1  signed overflow.
- zero  output  1  z == 0.
- neg  output  1  z[WIDTH-1].
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid.

Behaviour:
- Reset (rst=1 at an edge): state→IDLE. z=0, co=0, oflow=0, zero=0, neg=0, busy=0, done=0. Internal chunk index and carry are cleared. Reset wins over every other input.
- States:
  - IDLE: done=0, busy=0.
  - RUN: busy=1.
  - DONE: done=1, busy=0, lasts exactly 1 cycle.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --last chunk--> DONE.
  - DONE --start--> RUN (back-to-back start accepted).
  - DONE --no start--> IDLE.
- Start accepted at edge 0:
  - Latch a.
  - Latch b XOR {WIDTH{sub}}.
  - Carry register = sub ? ~ci : ci.
  - Chunk index = 0.
- Edges 1..NCHUNK: each edge adds chunk k of A, chunk k of B' and the carry register. Sum bits go to an internal result register; carry out goes to the carry register.
- Latency: at edge NCHUNK the state enters DONE and z, co, oflow, zero and neg update simultaneously. done is high for the cycle after edge NCHUNK. With the defaults, done is observed 2 cycles after the start edge.
- Output stability: outputs do not change during RUN. They hold their last values until the next completion or reset.
- Flags:
  - oflow = (carry into MSB) XOR (carry out of MSB).
  - co = carry out of MSB.
  - zero and neg are computed on the final z.
- start while busy=1 is ignored and has no effect on the in-flight operation. Operand changes after acceptance have no effect.
- Reset during RUN aborts the operation: no done pulse, and outputs return to reset values.
- If NCHUNK == 1, RUN lasts one cycle. Behaviour is otherwise identical.

Optional Feature:
- Macro: ADDSUB_SEQ_SATURATE_EN.
- Defined: when oflow=1, z is clamped.
  - If A's latched MSB is 0 (positive overflow), z = 0x7F..F (maximum).
  - If A's latched MSB is 1 (negative overflow), z = 0x80..0 (minimum).
  - oflow and co still report raw values. zero and neg reflect the clamped z.
- Undefined: z is the raw wrapped sum. No saturation logic is present.

Test Plan (WIDTH=8, CHUNK=4):
- Add overflow: a=0x70, b=0x10, sub=0, ci=0, start. Expect done 2 cycles after start with z=0x80, co=0, oflow=1, neg=1, zero=0. Saturation disabled.
- Subtract with borrow: a=0x05, b=0x07, sub=1, ci=0. Expect z=0xFE, co=0, oflow=0, neg=1. Then, with ci=1 (borrow-in), expect z=0xFD.
- Carry wrap to zero: a=0xFF, b=0x01, sub=0, ci=0. Expect z=0x00, co=1, zero=1, oflow=0, neg=0.
- Handshake:
  - Pulse start again 1 cycle after acceptance with different operands. It is ignored, and the first result is unchanged.
  - Assert start during the DONE cycle. It is accepted, busy=1 on the next cycle, and the second result arrives 2 cycles later.
- Reset mid-operation: start, then assert rst on the next edge. Expect busy=0, done never pulses, and all outputs=0. A subsequent start completes normally.
- Saturation (ADDSUB_SEQ_SATURATE_EN defined):
  - 0x70+0x10 → z=0x7F, oflow=1.
  - 0x80−0x01 (sub=1, ci=0) → z=0x80, oflow=1.
  - 0x10+0x20 → z=0x30, oflow=0.
